apb_reg_slave: RTL



---
 rtl/apb_reg_slave_if.sv | 24 ++
 rtl/apb_reg_slave.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge slave port and a register slave.
interface apb_reg_slave_if #(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    logic                   psel;
    logic                   penable;
    logic [PADDR_WIDTH-1:0] paddr;
    logic                   pwrite;
    logic [DATA_WIDTH-1:0]  pwdata;
    logic [DATA_WIDTH-1:0]  prdata;
    logic                   pready;
    logic                   pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register bank: 16 word registers in a 4 KB window, fixed wait states,
// PSLVERR on illegal accesses and saturating transfer/error counters.
module apb_reg_slave #(
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic           hclk,
    input  logic           hreset_n,
    apb_reg_slave_if.slave apb
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned STAT_W   = 16;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [STAT_W-1:0]       xfer_cnt_q, xfer_cnt_d;
    logic [STAT_W-1:0]       err_cnt_q, err_cnt_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic                    capture_c;
    logic                    done_c;
    logic [IDX_W-1:0]        setup_idx_c;
    logic                    setup_err_c;
    logic [DATA_WIDTH-1:0]   rdata_c;
    logic                    unused_addr_c;

    // Upper address bits are decoded by the bridge; only the 4 KB offset matters here.
    assign unused_addr_c = ^apb.paddr[PADDR_WIDTH-1:12];

    assign setup_idx_c = apb.paddr[5:2];
    assign setup_err_c = (apb.paddr[1:0] != 2'b00)
                      || (apb.paddr[11:6] != 6'b0)
                      || (apb.pwrite && ((setup_idx_c == IDX_W'(0))
                                      || (setup_idx_c == IDX_W'(NUM_REGS - 1))));

    // The bus SETUP phase is observed in IDLE (or in the completing cycle for
    // back-to-back); its controls are captured on that edge so the access
    // phase lasts exactly 1 + WAIT_CYCLES cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        capture_c = 1'b0;
        done_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    capture_c = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != CNT_W'(0)) begin
                    if (!apb.psel) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                    if (apb.psel && !apb.penable) begin
                        capture_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture_c) begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            idx_d   = setup_idx_c;
            write_d = apb.pwrite;
            wdata_d = apb.pwdata;
            err_d   = setup_err_c;
        end
    end

    // Commit write and statistics on the completing edge; errored writes never reach 0/15.
    always_comb begin
        regs_d     = regs_q;
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (done_c) begin
            if (write_q && !err_q) begin
                regs_d[idx_q] = wdata_q;
            end
            if (xfer_cnt_q != {STAT_W{1'b1}}) begin
                xfer_cnt_d = xfer_cnt_q + STAT_W'(1);
            end
            if (err_q && (err_cnt_q != {STAT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + STAT_W'(1);
            end
        end
    end

    // Read data uses next-state contents so a just-committed write is visible.
    always_comb begin
        rdata_c = regs_d[idx_d];
        if (idx_d == IDX_W'(0)) begin
            rdata_c = DATA_WIDTH'(ID_VALUE);
        end else if (idx_d == IDX_W'(NUM_REGS - 1)) begin
            rdata_c = DATA_WIDTH'({err_cnt_d, xfer_cnt_d});
        end
    end

    always_comb begin
        pready_d  = (state_d == ACCESS) && (cnt_d == CNT_W'(0));
        pslverr_d = pready_d && err_d;
        prdata_d  = (pready_d && !write_d && !err_d) ? rdata_c : '0;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;

endmodule
